control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have a parameter INSTR_W, default 32, giving the instruction width.
REQ-002 The block SHALL have port clock, input, 1 bit: single clock, all state changes on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port ir, input, 32 bits: IR contents from DataPath, with opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory data valid on Mdatain.
REQ-006 The block SHALL have port stop, input, 1 bit: halt request.
REQ-007 The block SHALL have outputs PCout, Zhighout, Zlowout, MDRout, each 1 bit: DataPath bus drivers.
REQ-008 The block SHALL have outputs MARin, PCin, MDRin, IRin, Yin, IncPC, Read, each 1 bit: DataPath load and strobe signals.
REQ-009 The block SHALL have outputs HIin, LOin, ZHighIn, ZLowIn, Cin, each 1 bit: result register loads.
REQ-010 The block SHALL have outputs reg_out_en, 1 bit, and reg_out_sel, 4 bits: GPR bus driver enable and index.
REQ-011 The block SHALL have outputs reg_in_en, 1 bit, and reg_in_sel, 4 bits: GPR load enable and index.
REQ-012 The block SHALL have output opcode, 5 bits: ALU operation.
REQ-013 The block SHALL have output run, 1 bit: high while the sequencer is executing.

Function
REQ-014 The state machine SHALL have states RST, T0, T1, T2, T3, T4, T5, T6, HALT, with one state per clock unless stalled.
REQ-015 Outputs SHALL be decoded from the current state and ir only (Moore); every output not listed for a state SHALL be 0, and opcode SHALL be 0 outside ALU steps.
REQ-016 RST: all outputs 0 and run=0; the next state SHALL be T0.
REQ-017 T0: PCout=1, MARin=1, IncPC=1, ZLowIn=1.
REQ-018 T1: Zlowout=1, PCin=1, Read=1, MDRin=1; the state SHALL stay in T1 while mem_ready=0 and advance to T2 on the first edge with mem_ready=1.
REQ-019 T2: MDRout=1, IRin=1.
REQ-020 Decode SHALL occur in T2 using the opcode table in the shared package.
REQ-021 Three-register ops SHALL be add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011.
REQ-022 Three-register ops SHALL execute as: T3 Rb out with Yin; T4 Rc out with ZLowIn and opcode=ir[31:27]; T5 Zlowout with Ra in; then T0.
REQ-023 mul 01111 and div 10000 SHALL execute as: T3 Ra out with Yin; T4 Rb out with ZHighIn, ZLowIn and opcode driven; T5 Zlowout with LOin; T6 Zhighout with HIin; then T0.
REQ-024 neg 10001 and not 10010 SHALL execute as: T3 Rb out with ZLowIn and opcode driven; T4 Zlowout with Ra in; then T0.
REQ-025 nop 11001 and any undefined opcode SHALL go from T2 to T0.
REQ-026 halt 11010 SHALL go from T2 to HALT.
REQ-027 HALT SHALL drive all outputs 0 and run=0, and SHALL be left only via clear.
REQ-028 stop=1 sampled on the final step of an instruction SHALL go to HALT instead of T0; stop in any other step SHALL have no effect.
REQ-029 Cycle counts excluding stalls SHALL be: three-register ops 6, mul/div 7, neg/not 5, nop 3.
REQ-030 Register indices SHALL pass through as 4-bit fields without remapping.

Reset
REQ-031 clear=1 at a rising edge SHALL force RST from any state, including mid-instruction and during a T1 stall; clear SHALL take priority over stop and mem_ready.
REQ-032 On the cycle after clear, all outputs SHALL be 0, run=0, and no GPR, HI or LO write SHALL occur.

Structure
REQ-033 Opcode constants and the state encoding SHALL live in a shared package cpu_defs, also used by DataPath.
REQ-034 One sub-module, instr_decode, SHALL be used: combinational decode of ir into an op class (ALU3, MULDIV, UNARY, NOP, HALT) plus the register fields.

Verification
REQ-035 Scenario: R3=0x7F, R7=1, ir=0x3A1B8000 (ror R4,R3,R7) -> R4=0x8000003F after T5, with opcode=00111 only in T4.
REQ-036 Scenario: mem_ready low for 3 cycles in T1 -> T1 held 4 cycles, Read and MDRin high throughout, T2 follows.
REQ-037 Scenario: mul R2,R5 with R2=0x10000, R5=0x10000 -> HI=1 and LO=0 after T6, instruction taking 7 cycles.
REQ-038 Scenario: clear asserted in T4 of an add -> next cycle RST with all outputs 0, destination register unchanged, T0 on the following cycle.
REQ-039 Scenario: opcode 11111 -> T2 returns to T0 with no reg_in_en pulse; opcode 11010 -> HALT with run=0 until clear.
REQ-040 Scenario: stop=1 during T5 of an add -> add completes, then HALT; stop=1 during T3 -> ignored.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode table, sequencer state encoding and the
// control word driven toward the DataPath.
package cpu_defs;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned REG_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        OC_ALU3, OC_MULDIV, OC_UNARY, OC_NOP, OC_HALT
    } op_class_e;

    typedef struct packed {
        logic             pc_out;
        logic             zhigh_out;
        logic             zlow_out;
        logic             mdr_out;
        logic             mar_in;
        logic             pc_in;
        logic             mdr_in;
        logic             ir_in;
        logic             y_in;
        logic             inc_pc;
        logic             read;
        logic             hi_in;
        logic             lo_in;
        logic             zhigh_in;
        logic             zlow_in;
        logic             c_in;
        logic             reg_out_en;
        logic [REG_W-1:0] reg_out_sel;
        logic             reg_in_en;
        logic [REG_W-1:0] reg_in_sel;
        logic [OPC_W-1:0] opcode;
        logic             run;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decode: op class plus the raw register fields.
module instr_decode
    import cpu_defs::*;
#(
    parameter int unsigned INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] ir,
    output op_class_e          op_class_c,
    output logic [OPC_W-1:0]   opc_c,
    output logic [REG_W-1:0]   ra_c,
    output logic [REG_W-1:0]   rb_c,
    output logic [REG_W-1:0]   rc_c
);

    localparam int unsigned OPC_LSB = INSTR_W - OPC_W;
    localparam int unsigned RA_LSB  = OPC_LSB - REG_W;
    localparam int unsigned RB_LSB  = RA_LSB - REG_W;
    localparam int unsigned RC_LSB  = RB_LSB - REG_W;

    logic unused_low_c;

    assign opc_c = ir[OPC_LSB +: OPC_W];
    assign ra_c  = ir[RA_LSB +: REG_W];
    assign rb_c  = ir[RB_LSB +: REG_W];
    assign rc_c  = ir[RC_LSB +: REG_W];

    // Low instruction bits carry no meaning for the sequencer.
    assign unused_low_c = ^ir[RC_LSB-1:0];

    // Undefined opcodes fall into the NOP class.
    always_comb begin
        op_class_c = OC_NOP;
        case (opc_c)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: op_class_c = OC_ALU3;
            OP_MUL, OP_DIV:                  op_class_c = OC_MULDIV;
            OP_NEG, OP_NOT:                  op_class_c = OC_UNARY;
            OP_HALT:                         op_class_c = OC_HALT;
            default:                         op_class_c = OC_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute steps driving the
// DataPath bus drivers, register loads and ALU operation.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [INSTR_W-1:0] ir,
    input  logic               mem_ready,
    input  logic               stop,
    output logic               PCout,
    output logic               Zhighout,
    output logic               Zlowout,
    output logic               MDRout,
    output logic               MARin,
    output logic               PCin,
    output logic               MDRin,
    output logic               IRin,
    output logic               Yin,
    output logic               IncPC,
    output logic               Read,
    output logic               HIin,
    output logic               LOin,
    output logic               ZHighIn,
    output logic               ZLowIn,
    output logic               Cin,
    output logic               reg_out_en,
    output logic [3:0]         reg_out_sel,
    output logic               reg_in_en,
    output logic [3:0]         reg_in_sel,
    output logic [4:0]         opcode,
    output logic               run
);

    state_e           state_q;
    state_e           state_d;
    op_class_e        op_class_c;
    logic [OPC_W-1:0] opc_c;
    logic [REG_W-1:0] ra_c;
    logic [REG_W-1:0] rb_c;
    logic [REG_W-1:0] rc_c;
    logic             last_step_c;
    ctrl_t            ctrl_c;

    instr_decode #(.INSTR_W(INSTR_W)) u_decode (
        .ir         (ir),
        .op_class_c (op_class_c),
        .opc_c      (opc_c),
        .ra_c       (ra_c),
        .rb_c       (rb_c),
        .rc_c       (rc_c)
    );

    always_ff @(posedge clock) begin
        if (clear) state_q <= ST_RST;
        else       state_q <= state_d;
    end

    // The final step of each class is where stop is honoured.
    always_comb begin
        last_step_c = 1'b0;
        case (state_q)
            ST_T2:   last_step_c = (op_class_c == OC_NOP);
            ST_T4:   last_step_c = (op_class_c == OC_UNARY);
            ST_T5:   last_step_c = (op_class_c == OC_ALU3);
            ST_T6:   last_step_c = 1'b1;
            default: last_step_c = 1'b0;
        endcase

        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2:   state_d = (op_class_c == OC_HALT) ? ST_HALT : ST_T3;
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = ST_T6;
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
        if (last_step_c) state_d = stop ? ST_HALT : ST_T0;
    end

    always_comb begin
        ctrl_c = '0;
        case (state_q)
            ST_T0: begin
                ctrl_c.pc_out  = 1'b1;
                ctrl_c.mar_in  = 1'b1;
                ctrl_c.inc_pc  = 1'b1;
                ctrl_c.zlow_in = 1'b1;
            end
            ST_T1: begin
                ctrl_c.zlow_out = 1'b1;
                ctrl_c.pc_in    = 1'b1;
                ctrl_c.read     = 1'b1;
                ctrl_c.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctrl_c.mdr_out = 1'b1;
                ctrl_c.ir_in   = 1'b1;
            end
            ST_T3: begin
                ctrl_c.reg_out_en = (op_class_c == OC_ALU3) || (op_class_c == OC_MULDIV)
                                    || (op_class_c == OC_UNARY);
                ctrl_c.reg_out_sel = (op_class_c == OC_MULDIV) ? ra_c : rb_c;
                ctrl_c.y_in        = (op_class_c == OC_ALU3) || (op_class_c == OC_MULDIV);
                if (op_class_c == OC_UNARY) begin
                    ctrl_c.zlow_in = 1'b1;
                    ctrl_c.opcode  = opc_c;
                end
                if (!ctrl_c.reg_out_en) ctrl_c.reg_out_sel = '0;
            end
            ST_T4: begin
                if (op_class_c == OC_ALU3 || op_class_c == OC_MULDIV) begin
                    ctrl_c.reg_out_en  = 1'b1;
                    ctrl_c.reg_out_sel = (op_class_c == OC_ALU3) ? rc_c : rb_c;
                    ctrl_c.zlow_in     = 1'b1;
                    ctrl_c.zhigh_in    = (op_class_c == OC_MULDIV);
                    ctrl_c.opcode      = opc_c;
                end else if (op_class_c == OC_UNARY) begin
                    ctrl_c.zlow_out   = 1'b1;
                    ctrl_c.reg_in_en  = 1'b1;
                    ctrl_c.reg_in_sel = ra_c;
                end
            end
            ST_T5: begin
                if (op_class_c == OC_ALU3) begin
                    ctrl_c.zlow_out   = 1'b1;
                    ctrl_c.reg_in_en  = 1'b1;
                    ctrl_c.reg_in_sel = ra_c;
                end else if (op_class_c == OC_MULDIV) begin
                    ctrl_c.zlow_out = 1'b1;
                    ctrl_c.lo_in    = 1'b1;
                end
            end
            ST_T6: begin
                ctrl_c.zhigh_out = 1'b1;
                ctrl_c.hi_in     = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
        ctrl_c.run = (state_q != ST_RST) && (state_q != ST_HALT);
    end

    assign PCout       = ctrl_c.pc_out;
    assign Zhighout    = ctrl_c.zhigh_out;
    assign Zlowout     = ctrl_c.zlow_out;
    assign MDRout      = ctrl_c.mdr_out;
    assign MARin       = ctrl_c.mar_in;
    assign PCin        = ctrl_c.pc_in;
    assign MDRin       = ctrl_c.mdr_in;
    assign IRin        = ctrl_c.ir_in;
    assign Yin         = ctrl_c.y_in;
    assign IncPC       = ctrl_c.inc_pc;
    assign Read        = ctrl_c.read;
    assign HIin        = ctrl_c.hi_in;
    assign LOin        = ctrl_c.lo_in;
    assign ZHighIn     = ctrl_c.zhigh_in;
    assign ZLowIn      = ctrl_c.zlow_in;
    assign Cin         = ctrl_c.c_in;
    assign reg_out_en  = ctrl_c.reg_out_en;
    assign reg_out_sel = ctrl_c.reg_out_sel;
    assign reg_in_en   = ctrl_c.reg_in_en;
    assign reg_in_sel  = ctrl_c.reg_in_sel;
    assign opcode      = ctrl_c.opcode;
    assign run         = ctrl_c.run;

endmodule
